// File: rtl/gb_lcd_capture.sv
// Game Boy LCD capture: synchronizes the LCD pins into clk, tracks line/pixel position
// and emits one framebuffer write per pixel. Optional error flag: define GB_CAPTURE_ERR_EN.
module gb_lcd_capture #(
    parameter int H_PIXELS    = 160,
    parameter int V_LINES     = 144,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gb_clk,
    input  logic        gb_hsync,
    input  logic        gb_vsync,
    input  logic [1:0]  gb_data,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [1:0]  wr_data,
    output logic        frame_done,
    output logic        frame_valid,
    output logic        err
);

    localparam int PIX_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam int SYNC_W = 5;

    localparam logic [0:0] ST_WAIT_VSYNC = 1'b0;
    localparam logic [0:0] ST_CAPTURE    = 1'b1;

    // Bit layout of a synchronizer word: {data[1:0], vsync, hsync, clk}
    logic [SYNC_W-1:0] sync_r [SYNC_STAGES];
    logic [SYNC_W-1:0] hist_r;
    logic [SYNC_W-1:0] sync_last_s;
    logic              clk_fall_s;
    logic              hsync_fall_s;
    logic              vsync_rise_s;
    logic [1:0]        data_s;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [PIX_W-1:0]  pix_r;
    logic [PIX_W-1:0]  pix_nxt_s;
    logic [LINE_W-1:0] line_r;
    logic [LINE_W-1:0] line_nxt_s;
    logic [14:0]       base_r;
    logic [14:0]       base_nxt_s;
    logic              wr_en_nxt_s;
    logic [14:0]       wr_addr_nxt_s;
    logic [1:0]        wr_data_nxt_s;
    logic              done_nxt_s;
    logic              valid_nxt_s;

    // Synchronizer chain plus one history stage for every LCD input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {SYNC_W{1'b0}};
            end
            hist_r <= {SYNC_W{1'b0}};
        end else begin
            sync_r[0] <= {gb_data, gb_vsync, gb_hsync, gb_clk};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_last_s  = sync_r[SYNC_STAGES-1];
    assign clk_fall_s   = hist_r[0] & ~sync_last_s[0];
    assign hsync_fall_s = hist_r[1] & ~sync_last_s[1];
    assign vsync_rise_s = ~hist_r[2] & sync_last_s[2];
    assign data_s       = sync_last_s[4:3];

    // Capture FSM: vsync has priority over hsync, hsync over the pixel clock.
    // base_r tracks line*H_PIXELS so the address needs only an adder.
    always_comb begin
        state_nxt_s   = state_r;
        pix_nxt_s     = pix_r;
        line_nxt_s    = line_r;
        base_nxt_s    = base_r;
        wr_en_nxt_s   = 1'b0;
        wr_addr_nxt_s = wr_addr;
        wr_data_nxt_s = wr_data;
        done_nxt_s    = 1'b0;
        valid_nxt_s   = frame_valid;
        case (state_r)
            ST_WAIT_VSYNC: begin
                if (vsync_rise_s) begin
                    state_nxt_s = ST_CAPTURE;
                    pix_nxt_s   = {PIX_W{1'b0}};
                    line_nxt_s  = {LINE_W{1'b0}};
                    base_nxt_s  = 15'd0;
                end else begin
                    state_nxt_s = ST_WAIT_VSYNC;
                end
            end
            ST_CAPTURE: begin
                if (vsync_rise_s) begin
                    pix_nxt_s  = {PIX_W{1'b0}};
                    line_nxt_s = {LINE_W{1'b0}};
                    base_nxt_s = 15'd0;
                end else if (hsync_fall_s) begin
                    // A latch before any pixel is the LCD's leading hsync; skip it
                    if (pix_r != {PIX_W{1'b0}}) begin
                        pix_nxt_s  = {PIX_W{1'b0}};
                        line_nxt_s = line_r + {{(LINE_W-1){1'b0}}, 1'b1};
                        base_nxt_s = base_r + 15'(H_PIXELS);
                        if (line_r == LINE_W'(V_LINES - 1)) begin
                            done_nxt_s  = 1'b1;
                            valid_nxt_s = 1'b1;
                            state_nxt_s = ST_WAIT_VSYNC;
                        end else begin
                            state_nxt_s = ST_CAPTURE;
                        end
                    end else begin
                        pix_nxt_s = pix_r;
                    end
                end else if (clk_fall_s) begin
                    if (pix_r < PIX_W'(H_PIXELS)) begin
                        wr_en_nxt_s   = 1'b1;
                        wr_addr_nxt_s = base_r + 15'(pix_r);
                        wr_data_nxt_s = data_s;
                        pix_nxt_s     = pix_r + {{(PIX_W-1){1'b0}}, 1'b1};
                    end else begin
                        pix_nxt_s = pix_r;
                    end
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_VSYNC;
            end
        endcase
    end

    // State, counters and registered framebuffer outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_WAIT_VSYNC;
            pix_r       <= {PIX_W{1'b0}};
            line_r      <= {LINE_W{1'b0}};
            base_r      <= 15'd0;
            wr_en       <= 1'b0;
            wr_addr     <= 15'd0;
            wr_data     <= 2'd0;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pix_r       <= pix_nxt_s;
            line_r      <= line_nxt_s;
            base_r      <= base_nxt_s;
            wr_en       <= wr_en_nxt_s;
            wr_addr     <= wr_addr_nxt_s;
            wr_data     <= wr_data_nxt_s;
            frame_done  <= done_nxt_s;
            frame_valid <= valid_nxt_s;
        end
    end

`ifdef GB_CAPTURE_ERR_EN
    logic err_evt_s;
    logic err_r;

    // Protocol violations seen while capturing: drops, short lines, early vsync, collisions
    always_comb begin
        err_evt_s = 1'b0;
        if (state_r == ST_CAPTURE) begin
            if (vsync_rise_s) begin
                err_evt_s = (line_r != {LINE_W{1'b0}}) || (pix_r != {PIX_W{1'b0}})
                            || hsync_fall_s || clk_fall_s;
            end else if (hsync_fall_s) begin
                err_evt_s = clk_fall_s
                            || ((pix_r != {PIX_W{1'b0}}) && (pix_r < PIX_W'(H_PIXELS)));
            end else if (clk_fall_s) begin
                err_evt_s = (pix_r >= PIX_W'(H_PIXELS));
            end else begin
                err_evt_s = 1'b0;
            end
        end else begin
            err_evt_s = 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_evt_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Bench for gb_lcd_capture: pixel-level model of the LCD stream predicts every write.
module tb_gb_lcd_capture;

    localparam int H  = 160;
    localparam int V  = 8;
    localparam int SS = 2;
`ifdef GB_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        gb_clk;
    logic        gb_hsync;
    logic        gb_vsync;
    logic [1:0]  gb_data;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;
    logic        frame_done;
    logic        frame_valid;
    logic        err;

    gb_lcd_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .gb_clk(gb_clk), .gb_hsync(gb_hsync),
        .gb_vsync(gb_vsync), .gb_data(gb_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .frame_valid(frame_valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model of the LCD position
    bit          m_cap;
    int          m_line;
    int          m_pix;
    int          m_done;
    bit          m_valid;
    bit          m_err;
    logic [16:0] exp_q[$];
    int          last_addr;

    // observations of the DUT
    int          done_cnt;
    int          wr_cnt;
    logic [1:0]  seen485;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pat(input int l, input int p);
        int v;
        v = (p ^ l) & 3;
        return 2'(v);
    endfunction

    task automatic model_hsync();
        if (m_cap && m_pix != 0) begin
            if (ERR_EN && m_pix < H) m_err = 1'b1;
            m_pix = 0;
            m_line++;
            if (m_line == V) begin
                m_done++;
                m_valid = 1'b1;
                m_cap = 1'b0;
            end
        end
    endtask

    task automatic gb_pix(input logic [1:0] d);
        gb_data = d;
        cyc(3);
        gb_clk = 1'b0;
        if (m_cap) begin
            if (m_pix < H) begin
                exp_q.push_back({15'(m_line * H + m_pix), d});
                m_pix++;
            end else if (ERR_EN) begin
                m_err = 1'b1;
            end
        end
        cyc(3);
        gb_clk = 1'b1;
    endtask

    task automatic hs_pulse();
        gb_hsync = 1'b1;
        cyc(3);
        gb_hsync = 1'b0;
        model_hsync();
        cyc(3);
    endtask

    task automatic vs_pulse();
        gb_vsync = 1'b1;
        if (ERR_EN && m_cap && (m_line != 0 || m_pix != 0)) m_err = 1'b1;
        m_cap = 1'b1;
        m_line = 0;
        m_pix = 0;
        cyc(3);
        gb_vsync = 1'b0;
        cyc(3);
    endtask

    // hsync and pixel clock fall together: pixel is discarded
    task automatic hs_and_clk();
        gb_hsync = 1'b1;
        cyc(3);
        gb_hsync = 1'b0;
        gb_clk = 1'b0;
        if (ERR_EN && m_cap) m_err = 1'b1;
        model_hsync();
        cyc(3);
        gb_clk = 1'b1;
        cyc(3);
    endtask

    task automatic settle_check(input string tag);
        cyc(8);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_done_cnt"}, done_cnt, m_done);
        chk({tag, "_valid"}, int'(frame_valid), int'(m_valid));
        chk({tag, "_err"}, int'(err), int'(m_err));
    endtask

    // Compare every write against the model, and address hold between writes
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            if (wr_en) begin
                wr_cnt++;
                if (wr_addr == 15'd485) seen485 = wr_data;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", int'(wr_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(e[16:2]));
                    chk("wr_data", int'(wr_data), int'(e[1:0]));
                    last_addr = int'(e[16:2]);
                end
            end else begin
                chk("addr_hold", int'(wr_addr), last_addr);
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        rst_n = 1'b0; gb_clk = 1'b1; gb_hsync = 1'b0; gb_vsync = 1'b0; gb_data = 2'd0;
        m_cap = 1'b0; m_line = 0; m_pix = 0; m_done = 0; m_valid = 1'b0; m_err = 1'b0;
        last_addr = 0; done_cnt = 0; wr_cnt = 0; seen485 = 2'd0;
        #2;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_frame_valid", int'(frame_valid), 0);
        chk("rst_err", int'(err), 0);
        cyc(5);
        rst_n = 1'b1;
        cyc(3);

        // pixels and hsync without vsync produce nothing
        for (int p = 0; p < 5; p++) gb_pix(2'd3);
        hs_pulse();
        settle_check("novsync");
        chk("novsync_writes", wr_cnt, 0);
        chk("novsync_valid_lit", int'(frame_valid), 0);

        // full frame with a leading hsync before the first pixel
        vs_pulse();
        hs_pulse();
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) gb_pix(pat(l, p));
            hs_pulse();
        end
        settle_check("frame");
        chk("frame_writes_lit", wr_cnt, H * V);
        chk("frame_last_addr_lit", int'(wr_addr), 1279);
        chk("frame_done_lit", done_cnt, 1);
        chk("frame_valid_lit", int'(frame_valid), 1);
        chk("pix485_data_lit", int'(seen485), 2);
        chk("frame_err_lit", int'(err), 0);

        // overlong line: two pixels dropped, next line at 160
        vs_pulse();
        for (int p = 0; p < H + 2; p++) gb_pix(2'd1);
        hs_pulse();
        gb_pix(2'd2);
        settle_check("drop");
        chk("drop_next_line_lit", int'(wr_addr), 160);
        chk("drop_err_lit", int'(err), int'(ERR_EN));

        // vsync mid-frame restarts at address 0 without frame_done
        for (int p = 0; p < 39; p++) gb_pix(2'd0);
        vs_pulse();
        gb_pix(2'd3);
        settle_check("restart");
        chk("restart_addr_lit", int'(wr_addr), 0);
        chk("restart_done_lit", done_cnt, 1);

        // hsync collides with a pixel clock edge: hsync wins
        for (int p = 0; p < 3; p++) gb_pix(2'd1);
        hs_and_clk();
        gb_pix(2'd2);
        settle_check("collide");
        chk("collide_addr_lit", int'(wr_addr), 160);

        // reset mid-frame at line 4
        vs_pulse();
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < H; p++) gb_pix(pat(l, p));
            hs_pulse();
        end
        for (int p = 0; p < 30; p++) gb_pix(2'd2);
        settle_check("prerst");
        rst_n = 1'b0;
        #2;
        chk("midrst_wr_addr", int'(wr_addr), 0);
        chk("midrst_valid", int'(frame_valid), 0);
        chk("midrst_wr_data", int'(wr_data), 0);
        m_cap = 1'b0; m_line = 0; m_pix = 0; m_valid = 1'b0; m_err = 1'b0;
        last_addr = 0;
        cyc(4);
        rst_n = 1'b1;
        cyc(3);
        wr_cnt = 0;
        for (int p = 0; p < 10; p++) gb_pix(2'd1);
        hs_pulse();
        settle_check("postrst");
        chk("postrst_writes", wr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_lcd_capture.md
GB_LCD_CAPTURE -- requirements
Module: gb_lcd_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 160, pixels per captured line.
REQ-002 SHALL have parameter V_LINES, default 144, lines per captured frame.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per async input (minimum 2).
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port gb_clk  input  1  Game Boy LCD pixel clock, asynchronous to clk.
REQ-007 SHALL have port gb_hsync  input  1  LCD line latch, asynchronous.
REQ-008 SHALL have port gb_vsync  input  1  LCD frame start, asynchronous.
REQ-009 SHALL have port gb_data  input  2  LCD pixel shade, asynchronous.
REQ-010 SHALL have port wr_en  output  1  framebuffer write strobe, one clk cycle per pixel.
REQ-011 SHALL have port wr_addr  output  15  framebuffer address, line*H_PIXELS + pixel.
REQ-012 SHALL have port wr_data  output  2  pixel shade written.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of a complete frame.
REQ-014 SHALL have port frame_valid  output  1  high once any frame has completed.
REQ-015 SHALL have port err  output  1  sticky protocol error flag (see Configuration).

Function
REQ-016 All four gb_* inputs SHALL pass through SYNC_STAGES flops, then one history flop for edge detection.
REQ-017 A gb_clk falling edge, gb_hsync falling edge and gb_vsync rising edge SHALL each be detected on synchronized signals only.
REQ-018 wr_en/wr_addr/wr_data SHALL be registered, asserting the cycle after edge detection (SYNC_STAGES+2 clk cycles after the pin edge).
REQ-019 wr_data SHALL be the synchronized gb_data value from the same stage as the detected gb_clk edge.
REQ-020 States: WAIT_VSYNC (reset state) and CAPTURE.
REQ-021 WAIT_VSYNC: ignore gb_clk/gb_hsync; gb_vsync rising edge -> line=0, pix=0, CAPTURE.
REQ-022 CAPTURE, gb_clk falling edge with pix<H_PIXELS: write addr line*H_PIXELS+pix, then pix+1.
REQ-023 CAPTURE, gb_clk falling edge with pix==H_PIXELS: no write; pixel dropped.
REQ-024 CAPTURE, gb_hsync falling edge with pix==0: ignored (leading latch before first pixel).
REQ-025 CAPTURE, gb_hsync falling edge with pix!=0: pix=0, line+1; if new line==V_LINES -> frame_done pulse, frame_valid=1, WAIT_VSYNC.
REQ-026 gb_vsync rising edge in CAPTURE SHALL restart the frame (line=0, pix=0) without frame_done.
REQ-027 Simultaneous events in one cycle: vsync beats hsync beats gb_clk; lower-priority event is discarded.
REQ-028 wr_addr SHALL hold its last value while wr_en is low; maximum address H_PIXELS*V_LINES-1 (23039 at defaults).
REQ-029 Integration constraint: clk frequency SHALL be at least 4x gb_clk frequency.

Reset
REQ-030 rst_n low SHALL asynchronously clear all synchronizer and history flops, counters, and outputs to 0, and force WAIT_VSYNC.
REQ-031 Reset asserted mid-frame SHALL abort capture; after release no write occurs until a new gb_vsync rising edge.

Configuration
REQ-032 Macro GB_CAPTURE_ERR_EN defined: err sets and stays set until reset on a dropped pixel (REQ-023), on hsync with 0<pix<H_PIXELS, on vsync in CAPTURE with line!=0 or pix!=0, or on a REQ-027 discard.
REQ-033 GB_CAPTURE_ERR_EN undefined: err tied 0 and no error logic synthesized; all other behaviour identical.

Verification
REQ-034 Reset, vsync, then 144 lines of 160 gb_clk edges each plus hsync -> 23040 writes, addresses 0..23039 in order, one frame_done, frame_valid=1, err=0.
REQ-035 Pixel 5 of line 3 driven gb_data=2'b10 -> write at wr_addr 485 with wr_data 2'b10.
REQ-036 Line with 162 gb_clk edges -> only 160 writes for that line; next line starts at line*160; err=1 only with macro.
REQ-037 vsync at line 70 pix 40 -> no frame_done; next write at address 0; err=1 only with macro.
REQ-038 rst_n low at line 100 -> all outputs 0 immediately; gb_clk edges before next vsync produce no writes.
REQ-039 gb_clk edges and hsync with no vsync after reset -> no writes, frame_valid=0.
